data_memory_pipe: RTL and testbench
===================================

// Module: data_memory_pipe
// PURPOSE
// - Parametrised byte-addressed data memory for the single-cycle/pipelined core; successor to the fixed 512-byte Data_Memory.
// - Word-organised RAM with RISC-V load/store sizing: LB/LH/LW/LBU/LHU loads, SB/SH/SW stores, little-endian.
// - Adds a valid/ready request port, a configurable read-latency pipeline with response backpressure, and misaligned-access error reporting.
// PARAMETERS
// - ADDR_W       9    byte-address width
// - DEPTH_WORDS  128  number of 32-bit words; power of two, <= 2**(ADDR_W-2)
// - RD_LATENCY   1    cycles from load accept to rsp_valid; legal range 1..4
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       asynchronous, active-low reset
// - req_valid   in   1       request present
// - req_ready   out  1       request accepted when req_valid && req_ready
// - mem_rd      in   1       load request
// - mem_wr      in   1       store request
// - addr        in   ADDR_W  byte address
// - load_type   in   3       000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// - store_type  in   3       000 SB, 001 SH, 010 SW
// - wd          in   32      store data, taken from the low bytes
// - rsp_valid   out  1       load response valid
// - rsp_ready   in   1       consumer accepts the response
// - rd          out  32      load data, sign- or zero-extended
// - rsp_err     out  1       response is for a faulting load
// BEHAVIOUR
// - Interface: one clock and one reset. Reset is asynchronous, active-low on rst_n.
// - Reset values: rsp_valid=0, rd=0, rsp_err=0, all pipeline valids=0.
//   - RAM contents are NOT cleared by rst_n; they are zero-initialised at time 0.
//   - rst_n mid-operation drops in-flight loads. Stores already accepted stay committed.
// - Stall: stall = rsp_valid && !rsp_ready. req_ready = !stall (combinational).
//   - While stalled, every pipeline stage holds and rd/rsp_err are stable.
// - Store: on accept with mem_wr=1 && mem_rd=0, the RAM is written at that clock edge.
//   - Byte lanes: SB writes lane addr[1:0]. SH writes lanes {addr[1],0}+{0,1}. SW writes all four lanes.
//   - A store produces no response.
// - Load: on accept with mem_rd=1 && mem_wr=0, the word is read at the accept edge.
//   - The result appears on rd with rsp_valid=1 exactly RD_LATENCY cycles later, absent stalls.
//   - Responses are in order. One request can be accepted per cycle. Throughput is 1 per cycle.
// - Extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
// - Load after store to the same address in the next cycle returns the new data (single port, no bypass needed).
// - Error cases: the request is accepted, no RAM write occurs, and a response with rd=0, rsp_err=1 is produced. Error cases are:
//   - LH/LHU/SH with addr[0]=1
//   - LW/SW with addr[1:0]!=0
//   - undefined load_type or store_type code
//   - mem_rd && mem_wr both 1
//   The error response follows the same RD_LATENCY timing.
// - Accept with mem_rd=0 && mem_wr=0: no-op, no response.
// - Word index = addr[ADDR_W-1:2]. Default wrap: index taken modulo DEPTH_WORDS, i.e. high bits ignored.
// CONFIGURATION
// - DMEM_BOUNDS_CHECK_EN defined:
//   - A word index >= DEPTH_WORDS counts as an error case: no write; for loads, rsp_err=1 and rd=0.
//   - For stores, only the write is suppressed; no response.
// - DMEM_BOUNDS_CHECK_EN undefined: out-of-range indices wrap modulo DEPTH_WORDS, no error. Keeps the legacy Data_Memory aliasing.
// TESTING
// - Reset, then LW addr=4: rd=0x00000000, rsp_valid high exactly RD_LATENCY cycles after accept, rsp_err=0.
// - SW addr=4 wd=7, then LW addr=4 on the next cycle: rd=7. Then SB addr=5 wd=0x80, LB addr=5: rd=0xFFFFFF80; LBU addr=5: rd=0x00000080.
// - SH addr=6 wd=0x1234ABCD, then LH addr=6: rd=0xFFFFABCD. LW addr=4: rd=0xABCD8007.
// - LW addr=5 and SH addr=3: no RAM change (LW addr=4 still 0xABCD8007). Misaligned load gives rsp_err=1, rd=0. mem_rd=mem_wr=1 gives rsp_err=1.
// - RD_LATENCY=3, four back-to-back loads, rsp_ready=0 for 2 cycles:
//   req_ready=0 while stalled, no response lost or reordered, rd held stable.
// - rst_n low with 2 loads in flight: rsp_valid=0 immediately, no stale response after release.
//   - DMEM_BOUNDS_CHECK_EN with DEPTH_WORDS=64, ADDR_W=9: LW addr=0x100 gives rsp_err=1. Without the macro it aliases to addr 0.

Source files
------------

// File: rtl/data_memory_pipe.sv
// Byte-addressed word RAM with RISC-V load/store sizing, a valid/ready request port and a
// stallable RD_LATENCY-deep response pipeline. Optional DMEM_BOUNDS_CHECK_EN faults out-of-range indices.
module data_memory_pipe #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH_WORDS = 128,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        load_type,
  input  logic [2:0]        store_type,
  input  logic [31:0]       wd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rd,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [2:0] ST_SB  = 3'b000;
  localparam logic [2:0] ST_SH  = 3'b001;
  localparam logic [2:0] ST_SW  = 3'b010;

  // No reset on the array: contents rely on power-up zero initialisation and survive rst_n.
  logic [31:0] mem [DEPTH_WORDS];

  logic             stall, accept, is_load, is_store;
  logic             load_err, store_err, oob, err, rsp_gen, wr_en;
  logic [IDX_W-1:0] widx;
  logic [31:0]      word, wdata;
  logic [3:0]       be;
  logic             unused_addr;

  logic             vld_p [RD_LATENCY];
  logic [31:0]      rd_p  [RD_LATENCY];
  logic             err_p [RD_LATENCY];

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] lt,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (lt)
      LT_LB:   return {{24{b[7]}}, b};
      LT_LBU:  return {24'b0, b};
      LT_LH:   return {{16{h[15]}}, h};
      LT_LHU:  return {16'b0, h};
      LT_LW:   return w;
      default: return '0;
    endcase
  endfunction

  assign stall       = rsp_valid && !rsp_ready;
  assign req_ready   = !stall;
  assign accept      = req_valid && req_ready;
  assign is_load     = mem_rd && !mem_wr;
  assign is_store    = mem_wr && !mem_rd;
  assign widx        = addr[IDX_W+1:2];
  assign word        = mem[widx];
  assign unused_addr = ^addr;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = 32'(addr[ADDR_W-1:2]) >= 32'(DEPTH_WORDS);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    case (load_type)
      LT_LB, LT_LBU: load_err = 1'b0;
      LT_LH, LT_LHU: load_err = addr[0];
      LT_LW:         load_err = |addr[1:0];
      default:       load_err = 1'b1;
    endcase
  end

  // Store lanes: replicate the source so the byte enables alone pick the target lanes.
  always_comb begin
    be        = 4'b0000;
    wdata     = wd;
    store_err = 1'b0;
    case (store_type)
      ST_SB: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{wd[7:0]}};
      end
      ST_SH: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{wd[15:0]}};
        store_err = addr[0];
      end
      ST_SW: begin
        be        = 4'b1111;
        store_err = |addr[1:0];
      end
      default: store_err = 1'b1;
    endcase
  end

  // Out-of-range stores are silently dropped; only loads report the bounds fault.
  assign err     = (mem_rd && mem_wr) || (is_load && (load_err || oob)) || (is_store && store_err);
  assign rsp_gen = accept && (is_load || err);
  assign wr_en   = accept && is_store && !store_err && !oob;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Stage 0 captures the extracted word at the accept edge; later stages shift unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        rd_p[i]  <= '0;
        err_p[i] <= 1'b0;
      end
    end else if (!stall) begin
      vld_p[0] <= rsp_gen;
      rd_p[0]  <= (rsp_gen && !err) ? extract(word, load_type, addr[1:0]) : '0;
      err_p[0] <= rsp_gen && err;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        rd_p[i]  <= rd_p[i-1];
        err_p[i] <= err_p[i-1];
      end
    end
  end

  assign rsp_valid = vld_p[RD_LATENCY-1];
  assign rd        = rd_p[RD_LATENCY-1];
  assign rsp_err   = err_p[RD_LATENCY-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe at RD_LATENCY=3, DEPTH_WORDS=64, ADDR_W=9.
// Bounds expectations follow DMEM_BOUNDS_CHECK_EN.
module tb_data_memory_pipe;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 64;
  localparam int LAT    = 3;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              mem_rd = 1'b0;
  logic              mem_wr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [2:0]        load_type = 3'b000;
  logic [2:0]        store_type = 3'b000;
  logic [31:0]       wd = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rd;
  logic              rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_pipe #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .load_type(load_type),
    .store_type(store_type), .wd(wd), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rd(rd), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request; then either a bounded wait for its response or a watch that none appears.
  task automatic xact(input string tag, input logic r, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [2:0] lt, input logic [2:0] st, input logic [31:0] d,
                      input bit exp_rsp, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; mem_rd = r; mem_wr = w; addr = a;
    load_type = lt; store_type = st; wd = d; rsp_ready = 1'b1;
    #1 check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if (exp_rsp) begin
      lat = 1;
      while (!rsp_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(LAT));
      check({tag, ".rd"}, rd, exp_rd);
      check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    end else begin
      seen = 0;
      for (int i = 0; i < LAT + 2; i++) begin
        if (rsp_valid) seen++;
        @(posedge clk); #1;
      end
      check({tag, ".no_rsp"}, 32'(seen), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp4 [4];
    logic [31:0] got4 [4];
    logic [31:0] held;
    int k, n, stalls, seen;
    bit was_st, acc;

    #3;
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rd", rd, 32'd0);
    check("reset.rsp_err", 32'(rsp_err), 32'd0);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    xact("lw4_init", 1, 0, 9'h004, LW,  SW, 0, 1, 32'h0000_0000, 0);
    xact("sw4",      0, 1, 9'h004, LW,  SW, 32'd7, 0, 0, 0);
    xact("lw4_a",    1, 0, 9'h004, LW,  SW, 0, 1, 32'h0000_0007, 0);
    xact("sb5",      0, 1, 9'h005, LB,  SB, 32'h80, 0, 0, 0);
    xact("lb5",      1, 0, 9'h005, LB,  SB, 0, 1, 32'hFFFF_FF80, 0);
    xact("lbu5",     1, 0, 9'h005, LBU, SB, 0, 1, 32'h0000_0080, 0);
    xact("sh6",      0, 1, 9'h006, LH,  SH, 32'h1234_ABCD, 0, 0, 0);
    xact("lh6",      1, 0, 9'h006, LH,  SH, 0, 1, 32'hFFFF_ABCD, 0);
    xact("lhu6",     1, 0, 9'h006, LHU, SH, 0, 1, 32'h0000_ABCD, 0);
    xact("lw4_b",    1, 0, 9'h004, LW,  SW, 0, 1, 32'hABCD_8007, 0);

    xact("lw5_mis",  1, 0, 9'h005, LW,  SW, 0, 1, 32'h0, 1);
    xact("lh7_mis",  1, 0, 9'h007, LH,  SW, 0, 1, 32'h0, 1);
    xact("sh3_mis",  0, 1, 9'h003, LW,  SH, 32'hFFFF_FFFF, 1, 32'h0, 1);
    xact("rdwr",     1, 1, 9'h004, LW,  SW, 32'h0, 1, 32'h0, 1);
    xact("lt_bad",   1, 0, 9'h004, 3'b011, SW, 0, 1, 32'h0, 1);
    xact("st_bad",   0, 1, 9'h004, LW, 3'b011, 32'h0, 1, 32'h0, 1);
    xact("noop",     0, 0, 9'h004, LW,  SW, 32'h0, 0, 0, 0);
    xact("lw4_kept", 1, 0, 9'h004, LW,  SW, 0, 1, 32'hABCD_8007, 0);

    xact("sw0",      0, 1, 9'h000, LW,  SW, 32'h0102_0304, 0, 0, 0);
    xact("sw8",      0, 1, 9'h008, LW,  SW, 32'hCAFE_F00D, 0, 0, 0);
    xact("sw12",     0, 1, 9'h00C, LW,  SW, 32'h0BAD_BEEF, 0, 0, 0);

    // Four back-to-back loads with rsp_ready low for two cycles once the first response arrives.
    exp4 = '{32'h0102_0304, 32'hABCD_8007, 32'hCAFE_F00D, 32'h0BAD_BEEF};
    k = 0; n = 0; stalls = 0; was_st = 0; held = '0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      req_valid = (k < 4); mem_rd = (k < 4); mem_wr = 1'b0;
      addr = 9'(k * 4); load_type = LW;
      rsp_ready = !(c == 3 || c == 4);
      #1;
      acc = req_valid && req_ready;
      if (rsp_valid && !rsp_ready) begin
        stalls++;
        check("bp.req_ready", 32'(req_ready), 32'd0);
        if (was_st) check("bp.rd_hold", rd, held);
        held = rd;
        was_st = 1;
      end else begin
        was_st = 0;
      end
      if (rsp_valid && rsp_ready && n < 4) begin
        got4[n] = rd;
        n++;
      end
      @(posedge clk);
      if (acc) k++;
    end
    @(negedge clk);
    req_valid = 1'b0; mem_rd = 1'b0; rsp_ready = 1'b1;
    check("bp.count", 32'(n), 32'd4);
    check("bp.stalls", 32'(stalls), 32'd2);
    for (int i = 0; i < 4; i++) check($sformatf("bp.rsp%0d", i), got4[i], exp4[i]);

    // Reset while loads are in flight and the first one is already presented.
    req_valid = 1'b1; mem_rd = 1'b1; addr = 9'h004; load_type = LW;
    @(posedge clk);
    @(negedge clk); addr = 9'h008;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0; mem_rd = 1'b0; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst.pre_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rd", rd, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("rst.no_stale", 32'(seen), 32'd0);
    xact("rst.mem_kept", 1, 0, 9'h004, LW, SW, 0, 1, 32'hABCD_8007, 0);

    // Word index 64 is out of range for a 64-word RAM.
    xact("sw100", 0, 1, 9'h100, LW, SW, 32'h55AA_55AA, 0, 0, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    xact("lw100", 1, 0, 9'h100, LW, SW, 0, 1, 32'h0, 1);
    xact("lw0_bounds", 1, 0, 9'h000, LW, SW, 0, 1, 32'h0102_0304, 0);
`else
    xact("lw100", 1, 0, 9'h100, LW, SW, 0, 1, 32'h55AA_55AA, 0);
    xact("lw0_alias", 1, 0, 9'h000, LW, SW, 0, 1, 32'h55AA_55AA, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
